conv_layer_inst_seq: RTL and testbench

//  Layer-level sequencer in front of the conv instruction-loop expander. It accepts one layer

---
 rtl/conv_layer_inst_seq.sv | 161 ++++++++++++++++
 tb/tb_conv_layer_inst_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_inst_seq.sv
// Layer-level sequencer: latches one layer descriptor and emits one conv instruction word
// per output position of a ROWS x COLS tile in raster order, on a registered valid/ready stream.
module conv_layer_inst_seq #(
    parameter int IRW = 30,
    parameter int IN  = 3,
    parameter int AW  = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [AW-1:0]       cfg_base,
    input  logic [6:0]          cfg_dim0,
    input  logic [6:0]          cfg_rows,
    input  logic [6:0]          cfg_cols,
    input  logic                cfg_fc,
    input  logic [IRW*IN-1:0]   cfg_tmpl,
    input  logic                abort,
    output logic [IRW*IN-1:0]   s_inst,
    output logic                s_valid,
    input  logic                s_ready,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    localparam int W = IRW * IN;

    // Stream handshake: a word transfers on a rising clk edge where s_valid & s_ready are
    // both high; while s_valid=1 and s_ready=0 the word is held and s_valid stays high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [6:0]      dim0_q;
    logic [6:0]      rows_q;
    logic [6:0]      cols_q;
    logic            fc_q;
    logic [W-1:0]    tmpl_q;
    logic [6:0]      r_q;
    logic [6:0]      c_q;
    logic [AW-1:0]   row_addr;
    logic [AW-1:0]   col_addr;

    logic            hs;
    logic            last_col;
    logic            last_row;
    logic [AW-1:0]   next_col_addr;
    logic [AW-1:0]   next_row_addr;

    assign dbg_state     = state;
    assign hs            = s_valid & s_ready;
    assign last_col      = (c_q == cols_q - 7'd1);
    assign last_row      = (r_q == rows_q - 7'd1);
    assign next_col_addr = col_addr + {{(AW-1){1'b0}}, 1'b1};
    assign next_row_addr = row_addr + {{(AW-7){1'b0}}, dim0_q};

    // Lane 0 carries fc, address and row pitch under the template's upper bits.
    function automatic logic [W-1:0] make_word(input logic [AW-1:0] addr,
                                               input logic [6:0]    dim0,
                                               input logic          fc,
                                               input logic [W-1:0]  tmpl);
        logic [W-1:0] w;
        w              = tmpl;
        w[0]           = fc;
        w[AW:1]        = addr;
        w[AW+7:AW+1]   = dim0;
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            s_valid   <= 1'b0;
            s_inst    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dim0_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            fc_q      <= 1'b0;
            tmpl_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            row_addr  <= '0;
            col_addr  <= '0;
        end else if (abort) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            s_valid   <= 1'b0;
            s_inst    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            row_addr  <= '0;
            col_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        dim0_q    <= cfg_dim0;
                        rows_q    <= cfg_rows;
                        cols_q    <= cfg_cols;
                        fc_q      <= cfg_fc;
                        tmpl_q    <= cfg_tmpl;
                        r_q       <= '0;
                        c_q       <= '0;
                        row_addr  <= cfg_base;
                        col_addr  <= cfg_base;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cfg_rows != 7'd0 && cfg_cols != 7'd0) begin
                            state   <= RUN;
                            s_valid <= 1'b1;
                            s_inst  <= make_word(cfg_base, cfg_dim0, cfg_fc, cfg_tmpl);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (last_col && last_row) begin
                            state   <= DONE;
                            s_valid <= 1'b0;
                            done    <= 1'b1;
                        end else if (!last_col) begin
                            c_q      <= c_q + 7'd1;
                            col_addr <= next_col_addr;
                            s_inst   <= make_word(next_col_addr, dim0_q, fc_q, tmpl_q);
                        end else begin
                            c_q      <= '0;
                            r_q      <= r_q + 7'd1;
                            row_addr <= next_row_addr;
                            col_addr <= next_row_addr;
                            s_inst   <= make_word(next_row_addr, dim0_q, fc_q, tmpl_q);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    r_q       <= '0;
                    c_q       <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_inst_seq.sv
// Directed bench for conv_layer_inst_seq: expected words are queued from a multiply-based
// address model when a descriptor is driven, and popped on every observed handshake.
module tb_conv_layer_inst_seq;

    localparam int IRW = 30;
    localparam int IN  = 3;
    localparam int AW  = 14;
    localparam int W   = IRW * IN;

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_base;
    logic [6:0]      cfg_dim0;
    logic [6:0]      cfg_rows;
    logic [6:0]      cfg_cols;
    logic            cfg_fc;
    logic [W-1:0]    cfg_tmpl;
    logic            abort;
    logic [W-1:0]    s_inst;
    logic            s_valid;
    logic            s_ready;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    int              checks;
    int              errors;
    int              hs_cnt;
    logic [W-1:0]    exp_q[$];

    logic            prev_stall;
    logic            prev_abort;
    logic [W-1:0]    prev_inst;

    conv_layer_inst_seq #(.IRW(IRW), .IN(IN), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_base  (cfg_base),
        .cfg_dim0  (cfg_dim0),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .cfg_fc    (cfg_fc),
        .cfg_tmpl  (cfg_tmpl),
        .abort     (abort),
        .s_inst    (s_inst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [AW-1:0] base, input logic [6:0] dim0,
                                              input int r, input int c, input logic fc,
                                              input logic [W-1:0] tmpl);
        logic [W-1:0]  w;
        logic [AW-1:0] a;
        a = AW'(int'(base) + r * int'(dim0) + c);
        w = tmpl;
        w[0] = fc;
        w[AW:1] = a;
        w[AW+7:AW+1] = dim0;
        return w;
    endfunction

    function automatic logic [W-1:0] rand_tmpl();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // driver: call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_cfg(input logic [AW-1:0] base, input logic [6:0] dim0,
                            input logic [6:0] rows, input logic [6:0] cols,
                            input logic fc, input logic [W-1:0] tmpl);
        for (int r = 0; r < int'(rows); r++)
            for (int c = 0; c < int'(cols); c++)
                exp_q.push_back(exp_word(base, dim0, r, c, fc, tmpl));
        cfg_base  = base;
        cfg_dim0  = dim0;
        cfg_rows  = rows;
        cfg_cols  = cols;
        cfg_fc    = fc;
        cfg_tmpl  = tmpl;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_base  = AW'($urandom_range(0, 16383));
        cfg_dim0  = 7'($urandom_range(0, 127));
        cfg_rows  = 7'($urandom_range(0, 127));
        cfg_cols  = 7'($urandom_range(0, 127));
        cfg_fc    = 1'($urandom_range(0, 1));
        cfg_tmpl  = rand_tmpl();
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                chk("hold_valid", W'(s_valid), W'(1));
                chk("hold_inst", s_inst, prev_inst);
            end
            if (s_valid && s_ready && !abort) begin
                hs_cnt++;
                chk("sb_nonempty", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) chk("word", s_inst, exp_q.pop_front());
            end
            prev_stall = s_valid && !s_ready;
            prev_abort = abort;
            prev_inst  = s_inst;
        end
    end

    initial begin
        bit seen;
        int hs0;
        logic [W-1:0] ones;
        checks = 0; errors = 0; hs_cnt = 0;
        prev_stall = 1'b0; prev_abort = 1'b0; prev_inst = '0;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_base = '0; cfg_dim0 = '0; cfg_rows = '0;
        cfg_cols = '0; cfg_fc = 1'b0; cfg_tmpl = '0; abort = 1'b0; s_ready = 1'b0;
        ones = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_cfg_ready", W'(cfg_ready), W'(1));
        chk("rst_s_valid", W'(s_valid), W'(0));
        chk("rst_s_inst", s_inst, '0);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));

        // 1: back-to-back 2x3 tile
        @(posedge clk); #1;
        s_ready = 1'b1;
        send_cfg(14'h100, 7'd16, 7'd2, 7'd3, 1'b0, rand_tmpl());
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_valid", W'(s_valid), W'(1));
            chk("t1_busy", W'(busy), W'(1));
            chk("t1_no_done", W'(done), W'(0));
        end
        @(negedge clk);
        chk("t1_done", W'(done), W'(1));
        chk("t1_valid_low", W'(s_valid), W'(0));
        chk("t1_cfg_ready_low", W'(cfg_ready), W'(0));
        @(negedge clk);
        chk("t1_done_pulse", W'(done), W'(0));
        chk("t1_cfg_ready", W'(cfg_ready), W'(1));
        chk("t1_sb_empty", W'(exp_q.size()), W'(0));

        // 2: same descriptor, s_ready toggling
        @(posedge clk); #1;
        hs0 = hs_cnt;
        s_ready = 1'b1;
        send_cfg(14'h100, 7'd16, 7'd2, 7'd3, 1'b0, rand_tmpl());
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            s_ready = ~s_ready;
        end
        chk("t2_done", W'(seen), W'(1));
        chk("t2_hs_count", W'(hs_cnt - hs0), W'(6));
        chk("t2_sb_empty", W'(exp_q.size()), W'(0));

        // 3: empty layer
        @(posedge clk); #1;
        s_ready = 1'b1;
        send_cfg(14'h040, 7'd3, 7'd0, 7'd5, 1'b1, rand_tmpl());
        @(negedge clk);
        chk("t3_done", W'(done), W'(1));
        chk("t3_no_valid", W'(s_valid), W'(0));
        chk("t3_cfg_ready_low", W'(cfg_ready), W'(0));
        @(negedge clk);
        chk("t3_done_pulse", W'(done), W'(0));
        chk("t3_cfg_ready", W'(cfg_ready), W'(1));
        chk("t3_no_valid2", W'(s_valid), W'(0));

        // 4: address wrap-around
        @(posedge clk); #1;
        send_cfg(14'h3FFE, 7'd1, 7'd1, 7'd4, 1'b0, rand_tmpl());
        wait_done(20, seen);
        chk("t4_done", W'(seen), W'(1));
        chk("t4_sb_empty", W'(exp_q.size()), W'(0));

        // 5: abort after the second handshake
        @(posedge clk); #1;
        hs0 = hs_cnt;
        send_cfg(14'h200, 7'd8, 7'd3, 7'd3, 1'b1, rand_tmpl());
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hs_cnt - hs0 >= 2) break;
        end
        chk("t5_two_hs", W'(hs_cnt - hs0), W'(2));
        @(posedge clk); #1;
        abort = 1'b1;
        s_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        s_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid_low", W'(s_valid), W'(0));
        chk("t5_idle", W'(dbg_state), W'(0));
        chk("t5_busy_low", W'(busy), W'(0));
        chk("t5_cfg_ready", W'(cfg_ready), W'(1));
        chk("t5_no_done", W'(done), W'(0));
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_done_later", W'(done), W'(0));
            chk("t5_no_valid_later", W'(s_valid), W'(0));
        end
        @(posedge clk); #1;
        send_cfg(14'h055, 7'd4, 7'd1, 7'd2, 1'b0, rand_tmpl());
        wait_done(20, seen);
        chk("t5_restart_done", W'(seen), W'(1));
        chk("t5_sb_empty", W'(exp_q.size()), W'(0));

        // 6: template / field packing
        @(posedge clk); #1;
        s_ready = 1'b0;
        send_cfg(14'h123, 7'h2A, 7'd1, 7'd2, 1'b1, ones);
        @(negedge clk);
        chk("t6_valid", W'(s_valid), W'(1));
        chk("t6_lanes12", W'(s_inst[W-1:IRW]), W'(ones[W-1:IRW]));
        chk("t6_fc", W'(s_inst[0]), W'(1));
        chk("t6_addr", W'(s_inst[AW:1]), W'(14'h123));
        chk("t6_dim0", W'(s_inst[AW+7:AW+1]), W'(7'h2A));
        chk("t6_upper", W'(s_inst[IRW-1:AW+8]), W'(ones[IRW-1:AW+8]));
        @(posedge clk); #1;
        s_ready = 1'b1;
        wait_done(20, seen);
        chk("t6_done", W'(seen), W'(1));
        chk("t6_sb_empty", W'(exp_q.size()), W'(0));

        // 7: reset in the middle of a layer
        @(posedge clk); #1;
        send_cfg(14'h0AB, 7'd5, 7'd4, 7'd4, 1'b0, rand_tmpl());
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t7_valid_low", W'(s_valid), W'(0));
        chk("t7_busy_low", W'(busy), W'(0));
        chk("t7_cfg_ready", W'(cfg_ready), W'(1));
        chk("t7_inst_zero", s_inst, '0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_cfg(14'h001, 7'd2, 7'd1, 7'd1, 1'b1, rand_tmpl());
        wait_done(20, seen);
        chk("t7_done", W'(seen), W'(1));
        chk("t7_sb_empty", W'(exp_q.size()), W'(0));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
